// File: rtl/visitor_serial_ctrl_pkg.sv
// visitor_ctrl_pkg: shared encodings for the visitor occupancy controller.
// Holds FSM state codes, serial op codes and default sizing constants.
package visitor_ctrl_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CAPACITY = 200;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        COMMIT
    } state_t;

    typedef enum logic {
        OP_INC,
        OP_DEC
    } op_t;

endpackage

// File: rtl/visitor_serial_ctrl_if.sv
// visitor_serial_ctrl_if: sensor-request / occupancy-status bundle.
// master: drives entry_req, exit_req; observes count, busy, done, sat,
// drop, full, empty.  slave: the controller side of the same signals.
interface visitor_serial_ctrl_if
    import visitor_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             entry_req;
    logic             exit_req;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             sat;
    logic             drop;
    logic             full;
    logic             empty;

    modport master (
        output entry_req, exit_req,
        input  count, busy, done, sat, drop, full, empty
    );

    modport slave (
        input  entry_req, exit_req,
        output count, busy, done, sat, drop, full, empty
    );

endinterface

// File: rtl/visitor_serial_ctrl_fa_slice.sv
// serial_fa_slice: 1-bit full adder with a registered carry for bit-serial add.
// Ports: clk, rst (sync, active-high), clr (sync carry clear), en (advance
// carry), a, b (operand bits); sum (comb), carry (registered carry state).
module serial_fa_slice (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    logic cout;

    assign sum  = a ^ b ^ carry;
    assign cout = (a & b) | (carry & (a ^ b));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= cout;
        end
    end

endmodule

// File: rtl/visitor_serial_ctrl.sv
// visitor_serial_ctrl: bit-serial occupancy inc/dec with request arbitration.
// Ports: clk, rst (sync, active-high), bus (slave modport of
// visitor_serial_ctrl_if: entry_req/exit_req in; count, busy, done, sat,
// drop, full, empty out).  Macro VISITOR_CAP_EN enables the CAPACITY limit.
module visitor_serial_ctrl
    import visitor_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CAPACITY = DEF_CAPACITY
) (
    input  logic                   clk,
    input  logic                   rst,
    visitor_serial_ctrl_if.slave   bus
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    if (CAPACITY < 1 || CAPACITY > (2 ** WIDTH) - 1) begin : g_cap_chk
        $error("CAPACITY does not fit in WIDTH bits");
    end

    state_t           state_q, state_n;
    op_t              op_q, op_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] res_q, res_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic             pin_q, pin_n;
    logic             pout_q, pout_n;
    logic             done_q, done_n;
    logic             sat_q, sat_n;
    logic             drop_q, drop_n;
    logic             clr, en, a, b, sum, carry;
    logic             ent, ext, at_cap;

`ifdef VISITOR_CAP_EN
    assign at_cap   = count_q >= WIDTH'(CAPACITY);
    assign bus.full = at_cap;
`else
    assign at_cap   = 1'b0;
    assign bus.full = &count_q;
`endif

    serial_fa_slice u_fa (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    // DEC adds all-ones; INC adds one via b at bit 0 only.
    assign a   = count_q[idx_q];
    assign b   = (op_q == OP_DEC) || (idx_q == '0);
    assign ent = bus.entry_req | pin_q;
    assign ext = bus.exit_req | pout_q;

    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        count_n = count_q;
        res_n   = res_q;
        idx_n   = idx_q;
        pin_n   = pin_q;
        pout_n  = pout_q;
        done_n  = 1'b0;
        sat_n   = 1'b0;
        drop_n  = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;

        if (state_q != IDLE) begin
            if (bus.entry_req) begin
                if (pin_q) drop_n = 1'b1;
                else       pin_n  = 1'b1;
            end
            if (bus.exit_req) begin
                if (pout_q) drop_n = 1'b1;
                else        pout_n = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                // Whatever is effective here is consumed this cycle;
                // simultaneous entry and exit cancel out.
                pin_n  = 1'b0;
                pout_n = 1'b0;
                if (ent && !ext && at_cap) begin
                    sat_n = 1'b1;
                end else if (ent != ext) begin
                    op_n    = ent ? OP_INC : OP_DEC;
                    idx_n   = '0;
                    clr     = 1'b1;
                    state_n = ADD;
                end
            end
            ADD: begin
                en    = 1'b1;
                res_n = {sum, res_q[WIDTH-1:1]};
                idx_n = idx_q + 1'b1;
                if (idx_q == LAST) state_n = COMMIT;
            end
            COMMIT: begin
                state_n = IDLE;
                // Carry-out set means INC wrapped; clear means DEC from 0.
                if ((op_q == OP_INC) == carry) begin
                    sat_n = 1'b1;
                end else begin
                    count_n = res_q;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_INC;
            count_q <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            pin_q   <= 1'b0;
            pout_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            count_q <= count_n;
            res_q   <= res_n;
            idx_q   <= idx_n;
            pin_q   <= pin_n;
            pout_q  <= pout_n;
            done_q  <= done_n;
            sat_q   <= sat_n;
            drop_q  <= drop_n;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = state_q != IDLE;
    assign bus.done  = done_q;
    assign bus.sat   = sat_q;
    assign bus.drop  = drop_q;
    assign bus.empty = count_q == '0;

endmodule

// File: tb/tb_visitor_serial_ctrl.sv
// tb_visitor_serial_ctrl: directed checks of the serial occupancy controller.
// Drives the interface master side; expected values are hand-computed.
module tb_visitor_serial_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   vec = 0;
    int   bad = 0;
    int   drops;

    visitor_serial_ctrl_if #(.WIDTH(W)) bus ();

    visitor_serial_ctrl #(
        .WIDTH    (W),
        .CAPACITY (200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request in cycle 0, return positioned at cycle W+2.
    task automatic run_op(input bit inc);
        if (inc) bus.entry_req = 1'b1;
        else     bus.exit_req  = 1'b1;
        step();
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        repeat (W + 1) step();
    endtask

    initial begin
        rst = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        check("rst count", bus.count, 0);
        check("rst busy",  bus.busy,  0);
        check("rst done",  bus.done,  0);
        check("rst sat",   bus.sat,   0);
        check("rst drop",  bus.drop,  0);
        check("rst empty", bus.empty, 1);
        check("rst full",  bus.full,  0);

        // First increment: busy in cycles 1..9, result in cycle 10.
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        for (int c = 1; c <= W + 1; c++) begin
            check($sformatf("inc busy c%0d", c), bus.busy, 1);
            check($sformatf("inc done c%0d", c), bus.done, 0);
            step();
        end
        check("inc count", bus.count, 1);
        check("inc done",  bus.done,  1);
        check("inc busy",  bus.busy,  0);
        check("inc empty", bus.empty, 0);
        step();
        check("inc done pulse", bus.done, 0);

        repeat (4) run_op(1'b1);
        check("count 5", bus.count, 5);
        run_op(1'b0);
        check("dec count", bus.count, 4);
        check("dec done",  bus.done,  1);
        check("dec sat",   bus.sat,   0);

        repeat (4) run_op(1'b0);
        check("down count", bus.count, 0);
        check("down empty", bus.empty, 1);

        run_op(1'b0);
        check("underflow count", bus.count, 0);
        check("underflow sat",   bus.sat,   1);
        check("underflow done",  bus.done,  0);
        step();
        check("underflow sat pulse", bus.sat, 0);

        // Simultaneous entry and exit cancel.
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        step();
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("both busy c%0d", c), bus.busy, 0);
            check($sformatf("both done c%0d", c), bus.done, 0);
            check($sformatf("both sat c%0d", c),  bus.sat,  0);
            check($sformatf("both cnt c%0d", c),  bus.count, 0);
            step();
        end

        // Entry op; extra entry twice and exit once while busy.
        drops = 0;
        bus.entry_req = 1'b1;
        step();
        for (int c = 1; c <= W + 1; c++) begin
            if (bus.drop) drops++;
            bus.entry_req = (c == 2) || (c == 4);
            bus.exit_req  = (c == 6);
            step();
        end
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        if (bus.drop) drops++;
        check("pend count", bus.count, 1);
        check("pend done",  bus.done,  1);
        step();
        if (bus.drop) drops++;
        check("pend cancel busy", bus.busy, 0);
        step();
        check("pend drops",  drops,      1);
        check("pend busy2",  bus.busy,   0);
        check("pend done2",  bus.done,   0);
        check("pend sat2",   bus.sat,    0);
        check("pend count2", bus.count,  1);

        // Reset during the 4th ADD cycle, with an entry pending.
        bus.entry_req = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            bus.entry_req = (c == 2);
            rst = (c == 4);
            step();
        end
        rst = 1'b0;
        bus.entry_req = 1'b0;
        check("midrst count", bus.count, 0);
        check("midrst busy",  bus.busy,  0);
        check("midrst done",  bus.done,  0);
        for (int c = 0; c < W + 2; c++) begin
            check($sformatf("postrst busy c%0d", c), bus.busy, 0);
            check($sformatf("postrst done c%0d", c), bus.done, 0);
            step();
        end

`ifdef VISITOR_CAP_EN
        repeat (200) run_op(1'b1);
        check("cap count", bus.count, 200);
        check("cap full",  bus.full,  1);
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        check("cap sat",   bus.sat,   1);
        check("cap busy",  bus.busy,  0);
        check("cap count1", bus.count, 200);
        step();
        check("cap busy2", bus.busy,  0);
        check("cap sat2",  bus.sat,   0);
        run_op(1'b0);
        check("cap dec count", bus.count, 199);
        check("cap dec full",  bus.full,  0);
`else
        repeat (255) run_op(1'b1);
        check("max count", bus.count, 255);
        check("max full",  bus.full,  1);
        run_op(1'b1);
        check("wrap count", bus.count, 255);
        check("wrap sat",   bus.sat,   1);
        check("wrap done",  bus.done,  0);
        run_op(1'b0);
        check("max dec count", bus.count, 254);
        check("max dec done",  bus.done,  1);
        check("max dec full",  bus.full,  0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/visitor_serial_ctrl.md
Name: visitor_serial_ctrl

Overview:
- Sequences a single 1-bit full-adder slice bit-serially to increment or decrement the visitor occupancy count.
- Arbitrates between the entry-sensor and exit-sensor request streams and holds the committed count register.
- Sits between the debounced sensor pulse logic and the display/limit logic of the visitor counter.

Parameters:
- WIDTH, 8, bit width of the occupancy count and number of serial add cycles.
- CAPACITY, 200, maximum allowed occupancy. Used only when VISITOR_CAP_EN is defined.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- entry_req  input  1  one-cycle pulse, one visitor entered.
- exit_req  input  1  one-cycle pulse, one visitor left.
- count  output  WIDTH  committed occupancy.
- busy  output  1  serial operation in progress.
- done  output  1  one-cycle pulse; count just updated.
- sat  output  1  one-cycle pulse; operation suppressed by overflow, underflow or cap.
- drop  output  1  one-cycle pulse; request lost because the same type was already pending.
- full  output  1  count == 2^WIDTH-1 (CAPACITY when cap enabled).
- empty  output  1  count == 0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: count=0, busy=0, done=0, sat=0, drop=0, pending flags cleared, state IDLE, empty=1, full=0. Reset mid-operation aborts the op with no commit.
- Pending flags: pend_in and pend_out. A request arriving in any state other than IDLE sets its flag. If that flag is already set, the request is discarded and drop pulses the next cycle.
- IDLE:
  - Effective entry = entry_req | pend_in. Effective exit = exit_req | pend_out.
  - Both asserted: both are consumed, no op, no done; count unchanged.
  - Exactly one asserted: latch op (INC/DEC), clear its flag, idx=0, carry=0, go to ADD.
- ADD (WIDTH cycles, idx 0..WIDTH-1): slice inputs are a=count[idx] and b (INC: 1 only at idx 0; DEC: 1 every bit, i.e. add all-ones). The sum bit is shifted into the result register and carry is registered. After idx=WIDTH-1, go to COMMIT.
- COMMIT (1 cycle):
  - INC with final carry=1 (wrap): hold count, pulse sat.
  - DEC with final carry=0 (count was 0): hold count, pulse sat.
  - Otherwise count<=result and pulse done.
  - Then go to IDLE.
- Timing: request high in cycle 0 (IDLE) → ADD in cycles 1..WIDTH → COMMIT in cycle WIDTH+1 → new count and done (or sat) visible in cycle WIDTH+2.
- busy is high in cycles 1..WIDTH+1.
- A pending request is accepted in the cycle done is visible, so back-to-back operations take WIDTH+2 cycles each.
- full and empty are combinational from count.

Optional Feature:
- Macro: VISITOR_CAP_EN.
- Defined: in IDLE, an INC with count >= CAPACITY is not started. Its request is consumed, sat pulses the next cycle, and no ADD is run. full = (count >= CAPACITY).
- Undefined: CAPACITY is ignored, only the carry-based wrap check applies, and full = (count == 2^WIDTH-1).

Decomposition:
- Package visitor_ctrl_pkg holds:
  - state encoding: IDLE, ADD, COMMIT;
  - op encoding: OP_INC, OP_DEC;
  - default WIDTH constant.
- Sub-module serial_fa_slice: 1-bit full-adder combinational core plus registered carry, with a synchronous clear on op start.

Test Plan:
- Reset, then entry_req pulse in cycle 0 (WIDTH=8) → busy high cycles 1-9; count=1 and done=1 in cycle 10.
- count=5, exit_req pulse → count=4 after 10 cycles. count=0, exit_req → count stays 0, sat pulse, no done.
- count=255, VISITOR_CAP_EN undefined, entry_req → count stays 255, sat pulse. With the macro defined and count=200, entry_req → sat in the next cycle, busy never asserted.
- entry_req and exit_req in the same IDLE cycle → count unchanged, no done, no sat, busy stays low.
- During busy: entry_req twice then exit_req once → drop pulses once; pend_in and pend_out cancel at the next IDLE; count reflects only the original op.
- rst asserted in ADD cycle 4 → the next cycle shows count=0, busy=0, pending flags cleared, no done.
